controle_servo_pwm: RTL and testbench

CONTROLE_SERVO_PWM -- requirements
Module: controle_servo_pwm

---
 rtl/controle_servo_pwm_if.sv | 30 +++
 rtl/controle_servo_pwm.sv | 67 ++++++
 tb/tb_controle_servo_pwm.sv | 108 ++++++++++
 3 files changed

// File: rtl/controle_servo_pwm_if.sv
// rtl/controle_servo_pwm_if.sv - control and status signals of the servo PWM generator
interface controle_servo_pwm_if;
  logic       zera_s;
  logic       liga;
  logic [2:0] posicao;
  logic       pwm;
  logic       inicio_periodo;
  logic [2:0] posicao_atual;
  logic       ativo;

  modport master (
    output zera_s,
    output liga,
    output posicao,
    input  pwm,
    input  inicio_periodo,
    input  posicao_atual,
    input  ativo
  );

  modport slave (
    input  zera_s,
    input  liga,
    input  posicao,
    output pwm,
    output inicio_periodo,
    output posicao_atual,
    output ativo
  );
endinterface

// File: rtl/controle_servo_pwm.sv
// rtl/controle_servo_pwm.sv - servo PWM generator with per-period shadowed position and enable
module controle_servo_pwm #(
  parameter int M     = 1_000_000,
  parameter int N     = 20,
  parameter int BASE  = 50_000,
  parameter int PASSO = 7_000
) (
  input  logic                 clock,
  input  logic                 zera_as_n,
  controle_servo_pwm_if.slave  servo
);

  localparam logic [N-1:0] ULTIMO  = N'(M - 1);
  localparam logic [N-1:0] BASE_N  = N'(BASE);
  localparam logic [N-1:0] PASSO_N = N'(PASSO);

  logic [N-1:0] cnt;
  logic [N-1:0] cnt_next;
  logic [2:0]   pos_q;
  logic [2:0]   pos_next;
  logic         ativo_q;
  logic         ativo_next;
  logic         pwm_q;
  logic         pwm_next;
  logic [N-1:0] largura_next;

  // Next-state: free-running period counter, shadow load at the wrap, synchronous
  // clear taking priority. pwm is precomputed from the next state so the output
  // comes straight from a flop and the pulse starts exactly on cnt=0.
  always_comb begin
    cnt_next     = cnt + 1'b1;
    pos_next     = pos_q;
    ativo_next   = ativo_q;
    if (servo.zera_s) begin
      cnt_next   = '0;
      pos_next   = 3'd0;
      ativo_next = 1'b0;
    end else if (cnt == ULTIMO) begin
      cnt_next   = '0;
      pos_next   = servo.posicao;
      ativo_next = servo.liga;
    end
    largura_next = BASE_N + PASSO_N * N'(pos_next);
    pwm_next     = ativo_next && (cnt_next < largura_next);
  end

  // State registers; the asynchronous reset also kills an in-flight pulse at once.
  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      cnt     <= '0;
      pos_q   <= 3'd0;
      ativo_q <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      pos_q   <= pos_next;
      ativo_q <= ativo_next;
      pwm_q   <= pwm_next;
    end
  end

  assign servo.pwm            = pwm_q;
  assign servo.inicio_periodo = zera_as_n && (cnt == '0);
  assign servo.posicao_atual  = pos_q;
  assign servo.ativo          = ativo_q;

endmodule

// File: tb/tb_controle_servo_pwm.sv
// tb/tb_controle_servo_pwm.sv - directed self-checking bench for controle_servo_pwm
module tb_controle_servo_pwm;
  localparam int M = 20;

  logic clock;
  logic zera_as_n;
  int   total;
  int   bad;

  controle_servo_pwm_if bus ();

  controle_servo_pwm #(
    .M(20), .N(5), .BASE(4), .PASSO(2)
  ) dut (
    .clock     (clock),
    .zera_as_n (zera_as_n),
    .servo     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Checks len cycles of a period starting at cnt=0; at cycle chg the inputs are changed.
  task automatic period(input string tag, input int hi, input int pos_exp, input int ativo_exp,
                        input int len, input int chg, input logic [2:0] new_pos,
                        input logic new_liga, input logic new_zs);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s_pwm_c%0d", tag, i), int'(bus.pwm), (i < hi) ? 1 : 0);
      chk($sformatf("%s_ini_c%0d", tag, i), int'(bus.inicio_periodo), (i == 0) ? 1 : 0);
      chk($sformatf("%s_pos_c%0d", tag, i), int'(bus.posicao_atual), pos_exp);
      chk($sformatf("%s_atv_c%0d", tag, i), int'(bus.ativo), ativo_exp);
      if (i == chg) begin
        bus.posicao = new_pos;
        bus.liga    = new_liga;
        bus.zera_s  = new_zs;
      end
      tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    zera_as_n   = 1'b0;
    bus.zera_s  = 1'b0;
    bus.liga    = 1'b1;
    bus.posicao = 3'd0;

    repeat (3) @(negedge clock);
    chk("rst_pwm", int'(bus.pwm), 0);
    chk("rst_ini", int'(bus.inicio_periodo), 0);
    chk("rst_atv", int'(bus.ativo), 0);
    chk("rst_pos", int'(bus.posicao_atual), 0);

    zera_as_n = 1'b1;
    #1;
    period("p0", 0, 0, 0, M, -1, 3'd0, 1'b1, 1'b0);
    period("p1", 4, 0, 1, M, -1, 3'd0, 1'b1, 1'b0);
    period("p2", 4, 0, 1, M, -1, 3'd0, 1'b1, 1'b0);
    period("p3", 4, 0, 1, M, 2, 3'd3, 1'b1, 1'b0);
    period("p4", 10, 3, 1, M, 0, 3'd7, 1'b1, 1'b0);
    period("p5", 18, 7, 1, M, 5, 3'd0, 1'b1, 1'b0);
    period("p6", 4, 0, 1, M, 1, 3'd0, 1'b0, 1'b0);
    period("p7", 0, 0, 0, M, 7, 3'd0, 1'b1, 1'b0);
    period("p8", 4, 0, 1, M, -1, 3'd0, 1'b1, 1'b0);
    period("p9", 4, 0, 1, 12, 11, 3'd0, 1'b1, 1'b1);
    bus.zera_s = 1'b0;
    period("p10", 0, 0, 0, M, -1, 3'd0, 1'b1, 1'b0);
    period("p11", 4, 0, 1, M, -1, 3'd0, 1'b1, 1'b0);
    period("p12", 4, 0, 1, 2, -1, 3'd0, 1'b1, 1'b0);

    chk("mid_pwm_before", int'(bus.pwm), 1);
    zera_as_n = 1'b0;
    #1;
    chk("async_pwm", int'(bus.pwm), 0);
    chk("async_ini", int'(bus.inicio_periodo), 0);
    chk("async_atv", int'(bus.ativo), 0);
    repeat (2) @(negedge clock);
    chk("held_pwm", int'(bus.pwm), 0);
    zera_as_n = 1'b1;
    #1;
    period("r0", 0, 0, 0, M, -1, 3'd0, 1'b1, 1'b0);
    period("r1", 4, 0, 1, M, -1, 3'd0, 1'b1, 1'b0);
    period("r2", 4, 0, 1, M, -1, 3'd0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
